axi_lite_cfg_sequencer: RTL

Table-driven AXI4-Lite master that configures and sequences the I2C IP through its S00_AXI register slave, replacing the bench BFM in hardware builds. It walks an external command table of write, read, poll and end entries, issues one AXI4-Lite transaction at a time, checks every response, and reports completion or a coded error. It sits between system control logic (or a boot FSM) and the I2C IP's AXI4-Lite slave port.

---
 rtl/axi_lite_cfg_sequencer_if.sv | 39 +++
 rtl/axi_lite_cfg_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cfg_sequencer_if.sv
// AXI4-Lite bus bundle between the configuration sequencer (master) and a register slave.
// Handshake: a transfer happens on a rising edge where VALID and READY are both high;
// VALID, once raised, holds with stable payload until that edge, and never waits on READY.
interface axi_lite_cfg_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_cfg_sequencer.sv
// Table-driven AXI4-Lite master: walks WRITE/READ/POLL/END entries, one transaction at a time,
// checks every response and reports done or a coded error (1 BRESP, 2 RRESP, 3 timeout).
module axi_lite_cfg_sequencer #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    IDX_WIDTH      = 4,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [IDX_WIDTH-1:0]  err_idx,
  output logic [IDX_WIDTH-1:0]  tbl_idx,
  input  logic [1:0]            tbl_op,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  input  logic [DATA_WIDTH-1:0] tbl_mask,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [3:0]            state_dbg,
  axi_lite_cfg_sequencer_if.master m_axi
);
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_n;
  logic [IDX_WIDTH-1:0]  idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, mask_q, rdata_q;
  logic                  poll_q;
  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  tmo_hit, tmo_clr, tmo_inc, adv;
  logic [1:0]            err_code_n;
  logic                  aw_ok, w_ok;

  // A channel is "ok" once its VALID is down or is being accepted this cycle.
  assign aw_ok   = !awvalid_q || m_axi.AWREADY;
  assign w_ok    = !wvalid_q  || m_axi.WREADY;
  assign tmo_hit = (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n    = state;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    adv        = 1'b0;
    err_code_n = 2'd3;
    case (state)
      S_IDLE: if (start) state_n = S_FETCH;
      S_FETCH: begin
        tmo_clr = 1'b1;
        case (tbl_op)
          OP_WRITE: state_n = S_WR;
          OP_END:   state_n = S_DONE;
          default:  state_n = S_RD_ADDR;
        endcase
      end
      S_WR: begin
        tmo_inc = 1'b1;
        if (aw_ok && w_ok) begin
          state_n = S_WR_RESP;
          tmo_clr = 1'b1;
        end else if (tmo_hit) state_n = S_ERROR;
      end
      S_WR_RESP: begin
        tmo_inc = 1'b1;
        if (m_axi.BVALID) begin
          if (m_axi.BRESP == RESP_OKAY) begin
            state_n = S_FETCH;
            adv     = 1'b1;
          end else begin
            state_n    = S_ERROR;
            err_code_n = 2'd1;
          end
        end else if (tmo_hit) state_n = S_ERROR;
      end
      S_RD_ADDR: begin
        tmo_inc = 1'b1;
        if (m_axi.ARREADY) begin
          state_n = S_RD_DATA;
          tmo_clr = !poll_q;  // a poll loop keeps one budget across reissues
        end else if (tmo_hit) state_n = S_ERROR;
      end
      S_RD_DATA: begin
        tmo_inc = 1'b1;
        if (m_axi.RVALID) begin
          if (m_axi.RRESP != RESP_OKAY) begin
            state_n    = S_ERROR;
            err_code_n = 2'd2;
          end else if (poll_q) state_n = S_CHECK;
          else begin
            state_n = S_FETCH;
            adv     = 1'b1;
          end
        end else if (tmo_hit) state_n = S_ERROR;
      end
      S_CHECK: begin
        tmo_inc = 1'b1;
        if ((rdata_q & mask_q) == (data_q & mask_q)) begin
          state_n = S_FETCH;
          adv     = 1'b1;
        end else if (tmo_hit) state_n = S_ERROR;
        else state_n = S_RD_ADDR;
      end
      S_DONE: state_n = S_IDLE;
      S_ERROR: if (aw_ok && w_ok && (!arvalid_q || m_axi.ARREADY)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      idx       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
      poll_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      err_idx   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      rd_valid <= 1'b0;
      if (tmo_clr) tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_IDLE && start) begin
        idx      <= '0;
        error    <= 1'b0;
        err_code <= 2'd0;
        busy     <= 1'b1;
      end
      if (state == S_FETCH) begin
        addr_q <= BASE_ADDR + tbl_addr;
        data_q <= tbl_data;
        mask_q <= tbl_mask;
        poll_q <= (tbl_op == OP_POLL);
      end
      if (state == S_FETCH && state_n == S_WR) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end else begin
        if (m_axi.AWREADY) awvalid_q <= 1'b0;
        if (m_axi.WREADY)  wvalid_q  <= 1'b0;
      end
      if (state_n == S_RD_ADDR && state != S_RD_ADDR) arvalid_q <= 1'b1;
      else if (m_axi.ARREADY) arvalid_q <= 1'b0;
      if (state == S_RD_DATA && m_axi.RVALID) begin
        rdata_q <= m_axi.RDATA;
        if (!poll_q && m_axi.RRESP == RESP_OKAY) begin
          rd_data  <= m_axi.RDATA;
          rd_valid <= 1'b1;
        end
      end
      if (adv) idx <= idx + 1'b1;
      if (state_n == S_DONE) busy <= 1'b0;
      if (state_n == S_ERROR && state != S_ERROR) begin
        error    <= 1'b1;
        err_code <= err_code_n;
        err_idx  <= idx;
        busy     <= 1'b0;
      end
    end
  end

  assign done      = (state == S_DONE);
  assign tbl_idx   = idx;
  assign state_dbg = state;

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = data_q;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = (state == S_WR_RESP);
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = (state == S_RD_DATA);
endmodule
